// File: rtl/uart_tx.sv
// Serial framer: start bit, LSB-first payload, optional even parity, stop bit.
// Parity bit and PARITY state exist only when UART_TX_PARITY_EN is defined.
module uart_tx #(
    parameter int   DATA_BITS    = 8,
    parameter int   CLKS_PER_BIT = 1,
    parameter logic IDLE_LEVEL   = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 data_valid,
    output logic                 data_ready,
    output logic                 signal,
    output logic                 busy
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] BIT_LAST  = IW'(DATA_BITS - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t               state, state_n;
    logic [CW-1:0]        baud, baud_n;
    logic [IW-1:0]        bit_idx, bit_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 signal_n, ready_n, busy_n;
    logic                 baud_done;
`ifdef UART_TX_PARITY_EN
    logic                 parity, parity_n;
`endif

    assign baud_done = (baud == BAUD_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            baud       <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            signal     <= IDLE_LEVEL;
            data_ready <= 1'b0;
            busy       <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity     <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            baud       <= baud_n;
            bit_idx    <= bit_n;
            shreg      <= shreg_n;
            signal     <= signal_n;
            data_ready <= ready_n;
            busy       <= busy_n;
`ifdef UART_TX_PARITY_EN
            parity     <= parity_n;
`endif
        end
    end

    always_comb begin
        state_n  = state;
        baud_n   = baud;
        bit_n    = bit_idx;
        shreg_n  = shreg;
        signal_n = signal;
        ready_n  = data_ready;
        busy_n   = busy;
`ifdef UART_TX_PARITY_EN
        parity_n = parity;
`endif
        // Baud counter free-runs while a frame is on the line.
        if (state != IDLE)
            baud_n = baud_done ? '0 : baud + 1'b1;

        case (state)
            IDLE: begin
                ready_n  = 1'b1;
                busy_n   = 1'b0;
                signal_n = IDLE_LEVEL;
                baud_n   = '0;
                bit_n    = '0;
                if (data_valid && data_ready) begin
                    shreg_n  = data_in;
`ifdef UART_TX_PARITY_EN
                    parity_n = ^data_in;
`endif
                    state_n  = START;
                    signal_n = ~IDLE_LEVEL;
                    ready_n  = 1'b0;
                    busy_n   = 1'b1;
                end
            end
            START: begin
                if (baud_done) begin
                    state_n  = DATA;
                    signal_n = shreg[0];
                end
            end
            DATA: begin
                if (baud_done) begin
                    if (bit_idx == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_n  = PARITY;
                        signal_n = parity;
`else
                        state_n  = STOP;
                        signal_n = IDLE_LEVEL;
`endif
                    end else begin
                        // Shift so the next bit to send is always at bit 0.
                        bit_n    = bit_idx + 1'b1;
                        shreg_n  = shreg >> 1;
                        signal_n = shreg_n[0];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_done) begin
                    state_n  = STOP;
                    signal_n = IDLE_LEVEL;
                end
            end
`endif
            STOP: begin
                if (baud_done) begin
                    state_n = IDLE;
                    ready_n = 1'b1;
                    busy_n  = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule
